// File: rtl/idct_pkg.sv
// Shared types and constants for the IDCT/IFFT input framer.
package idct_pkg;

  localparam int FFTPTS_W = 12;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_RESYNC = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  // Per-beat sideband that travels in the same buffer entry as the sample data.
  typedef struct packed {
    logic                sop;
    logic                eop;
    logic [1:0]          err;
    logic [FFTPTS_W-1:0] fftpts;
  } beat_tag_t;

  localparam int TAG_W = $bits(beat_tag_t);

endpackage

// File: rtl/idct_skid_buf.sv
// Two-entry valid/ready buffer: an output register plus one skid register.
// Upstream ready is the registered "skid empty" flag, so it never depends
// combinationally on downstream ready.
module idct_skid_buf #(
  parameter int W = 76
) (
  input  logic         clk,
  input  logic         rst_sync,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;

  logic w_accept;
  logic w_drain;

  // An input is taken whenever the skid slot is free; the output slot may
  // be refilled whenever it is empty or being consumed this cycle.
  assign w_accept = i_valid & ~r_skid_valid;
  assign w_drain  = ~r_out_valid | i_ready;

  // Move data skid -> output when possible, otherwise park new input in the skid.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_drain) begin
      if (r_skid_valid) begin
        // Skid full implies no input was accepted this cycle.
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_data <= i_data;
        end
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_data;
    end
  end

  assign o_ready = ~r_skid_valid;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule

// File: rtl/idct_fft_framer.sv
// Input-side framer for the IDCT/IFFT core: sign-extends and pre-scales each
// complex sample, tags frame boundaries (sop/eop/fftpts) and a resync error,
// and hands beats to the FFT core through a two-entry skid buffer.
module idct_fft_framer
  import idct_pkg::*;
#(
  parameter int wDataIn  = 24,
  parameter int wDataOut = 30,
  parameter int SHIFT    = 4
) (
  input  logic                clk,
  input  logic                rst_sync,
  input  logic                sink_valid,
  output logic                sink_ready,
  input  logic                sink_sop,
  input  logic [wDataIn-1:0]  sink_real,
  input  logic [wDataIn-1:0]  sink_imag,
  input  logic [FFTPTS_W-1:0] fftpts_in,
  output logic                source_valid,
  input  logic                source_ready,
  output logic                source_sop,
  output logic                source_eop,
  output logic [wDataOut-1:0] source_real,
  output logic [wDataOut-1:0] source_imag,
  output logic [1:0]          source_error,
  output logic [FFTPTS_W-1:0] fftpts_out
);

  localparam int PAY_W = TAG_W + 2 * wDataOut;

  fsm_state_t          r_state;
  fsm_state_t          w_state_next;
  logic [FFTPTS_W-1:0] r_cnt;
  logic [FFTPTS_W-1:0] w_cnt_next;
  logic [FFTPTS_W-1:0] r_len;
  logic [FFTPTS_W-1:0] w_len_next;
  logic [FFTPTS_W-1:0] r_fftpts;
  logic [FFTPTS_W-1:0] w_fftpts_next;

  logic                w_accept;
  logic                w_start;
  logic                w_resync;
  logic [FFTPTS_W-1:0] w_new_len;
  beat_tag_t           w_in_tag;
  beat_tag_t           w_out_tag;

  logic [1:0][wDataIn-1:0]  w_lane_in;
  logic [1:0][wDataOut-1:0] w_lane_out;
  logic [PAY_W-1:0]         w_in_data;
  logic [PAY_W-1:0]         w_out_data;

  assign w_accept  = sink_valid & sink_ready;
  // A frame starts on any accept from IDLE, or on a resync marker mid-frame.
  assign w_start   = (r_state == IDLE) | sink_sop;
  assign w_resync  = (r_state == RUN) & sink_sop;
  // Length minus one with 12-bit wrap, so a request of 0 means 4096 points.
  assign w_new_len = fftpts_in - FFTPTS_W'(1);

  // Sign-extend each lane to the output width, then append SHIFT zero LSBs.
  assign w_lane_in = {sink_real, sink_imag};
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign w_lane_out[gi] = wDataOut'($signed(w_lane_in[gi])) << SHIFT;
  end

  // State register: frame FSM, beat counter and latched frame length.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_len    <= '0;
      r_fftpts <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_len    <= w_len_next;
      r_fftpts <= w_fftpts_next;
    end
  end

  // Next-state logic: advance only on an accepted sample.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_len_next    = r_len;
    w_fftpts_next = r_fftpts;
    if (w_accept) begin
      if (w_start) begin
        w_len_next    = w_new_len;
        w_fftpts_next = fftpts_in;
        if (w_new_len == '0) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_state_next = RUN;
          w_cnt_next   = FFTPTS_W'(1);
        end
      end else if (r_cnt == r_len) begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next = r_cnt + FFTPTS_W'(1);
      end
    end
  end

  // Output logic: sideband tags for the sample being presented upstream.
  always_comb begin
    w_in_tag        = '0;
    w_in_tag.sop    = w_start;
    w_in_tag.eop    = w_start ? (w_new_len == '0) : (r_cnt == r_len);
    w_in_tag.err    = w_resync ? ERR_RESYNC : ERR_NONE;
    w_in_tag.fftpts = w_start ? fftpts_in : r_fftpts;
  end

  assign w_in_data = {w_in_tag, w_lane_out[1], w_lane_out[0]};

  idct_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk      (clk),
    .rst_sync (rst_sync),
    .i_valid  (sink_valid),
    .o_ready  (sink_ready),
    .i_data   (w_in_data),
    .o_valid  (source_valid),
    .i_ready  (source_ready),
    .o_data   (w_out_data)
  );

  assign {w_out_tag, source_real, source_imag} = w_out_data;
  assign source_sop   = w_out_tag.sop;
  assign source_eop   = w_out_tag.eop;
  assign source_error = w_out_tag.err;
  assign fftpts_out   = w_out_tag.fftpts;

endmodule

// File: tb/tb_idct_fft_framer.sv
// Directed bench for idct_fft_framer: frame tagging, scaling, backpressure,
// resync and reset. Outputs are sampled on the falling edge.
module tb_idct_fft_framer;

  logic        clk = 1'b0;
  logic        rst_sync = 1'b1;
  logic        sink_valid = 1'b0;
  logic        sink_ready;
  logic        sink_sop = 1'b0;
  logic [23:0] sink_real = '0;
  logic [23:0] sink_imag = '0;
  logic [11:0] fftpts_in = '0;
  logic        source_valid;
  logic        source_ready = 1'b1;
  logic        source_sop;
  logic        source_eop;
  logic [29:0] source_real;
  logic [29:0] source_imag;
  logic [1:0]  source_error;
  logic [11:0] fftpts_out;

  idct_fft_framer #(
    .wDataIn  (24),
    .wDataOut (30),
    .SHIFT    (4)
  ) dut (
    .clk          (clk),
    .rst_sync     (rst_sync),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .fftpts_in    (fftpts_in),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .source_error (source_error),
    .fftpts_out   (fftpts_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [75:0] word;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_sop = 0;
  int          n_eop = 0;
  int          n_err = 0;
  int          n_beats = 0;
  bit          lat_chk = 1'b0;
  bit          last_in_acc = 1'b0;
  bit          prev_stall = 1'b0;
  logic [75:0] prev_word = '0;

  // Bench frame model: position within the frame and frame size.
  bit          m_in_frame = 1'b0;
  int          m_pos = 0;
  int          m_n = 0;
  logic [11:0] m_fp = '0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] scale(input logic [23:0] x);
    longint v;
    v = longint'($signed(x)) * 16;
    return v[29:0];
  endfunction

  // One clock: score handshakes at the current falling edge, then advance.
  task automatic step();
    logic [75:0] cur;
    exp_t        e;
    bit          st;
    logic [1:0]  er;
    bit          sp, ep;
    cur = {source_sop, source_eop, source_error, fftpts_out, source_real, source_imag};
    last_in_acc = 1'b0;
    if (rst_sync) begin
      exp_q.delete();
      m_in_frame = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && source_valid) check("hold_stable", 80'(cur), 80'(prev_word));
      if (source_valid && source_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_expected", 80'(exp_q.size()), 80'd1);
        end else begin
          e = exp_q.pop_front();
          check("beat", 80'(cur), 80'(e.word));
          if (lat_chk) check("latency", 80'(cyc - e.cyc), 80'd1);
          $display("beat %0d: sop=%0b eop=%0b err=%0d pts=%0d re=%h im=%h", n_beats,
                   source_sop, source_eop, source_error, fftpts_out, source_real, source_imag);
          n_beats++;
          if (source_sop) n_sop++;
          if (source_eop) n_eop++;
          if (source_error != 2'b00) n_err++;
        end
      end
      prev_stall = source_valid & ~source_ready;
      prev_word  = cur;
      if (sink_valid && sink_ready) begin
        st = !m_in_frame || sink_sop;
        er = (m_in_frame && sink_sop) ? 2'b01 : 2'b00;
        if (st) begin
          m_n   = (fftpts_in == 12'd0) ? 4096 : int'(fftpts_in);
          m_pos = 0;
          m_fp  = fftpts_in;
        end
        sp = (m_pos == 0);
        ep = (m_pos == m_n - 1);
        m_pos++;
        m_in_frame = (m_pos != m_n);
        e.word = {sp, ep, er, m_fp, scale(sink_real), scale(sink_imag)};
        e.cyc  = cyc;
        exp_q.push_back(e);
        last_in_acc = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Offer one sample until accepted. rmode: 0 ready high, 1 random ready.
  task automatic send(input logic [11:0] fp, input bit sop_in, input int rmode,
                      input logic [23:0] re, input logic [23:0] im);
    int k;
    sink_valid = 1'b1;
    sink_sop   = sop_in;
    fftpts_in  = fp;
    sink_real  = re;
    sink_imag  = im;
    k = 0;
    do begin
      source_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      k++;
    end while (!last_in_acc && k < 200);
    if (!last_in_acc) check("accept_timeout", 80'(last_in_acc), 80'd1);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
  endtask

  task automatic drain(input int n);
    sink_valid   = 1'b0;
    source_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    check("drain_empty", 80'(exp_q.size()), 80'd0);
  endtask

  initial begin
    int s0, e0, r0;

    // Reset state
    rst_sync = 1'b1;
    step();
    step();
    rst_sync = 1'b0;
    check("rst_valid", 80'(source_valid), 80'd0);
    check("rst_sop", 80'(source_sop), 80'd0);
    check("rst_eop", 80'(source_eop), 80'd0);
    check("rst_err", 80'(source_error), 80'd0);
    check("rst_data", 80'({source_real, source_imag}), 80'd0);
    check("rst_pts", 80'(fftpts_out), 80'd0);
    check("rst_ready", 80'(sink_ready), 80'd1);

    // 1: two frames of 8 back to back, 1-cycle latency
    s0 = n_sop; e0 = n_eop;
    lat_chk = 1'b1;
    for (int i = 0; i < 16; i++) send(12'd8, 1'b0, 0, 24'($urandom), 24'($urandom));
    drain(3);
    lat_chk = 1'b0;
    check("t1_sops", 80'(n_sop - s0), 80'd2);
    check("t1_eops", 80'(n_eop - e0), 80'd2);

    // 2: scaling of extreme values
    send(12'd1, 1'b0, 0, 24'hFFFFFF, 24'h7FFFFF);
    check("t2_valid", 80'(source_valid), 80'd1);
    check("t2_real", 80'(source_real), 80'h3FFFFFF0);
    check("t2_imag", 80'(source_imag), 80'h07FFFFF0);
    drain(2);

    // 3a: one-point frames
    s0 = n_sop; e0 = n_eop;
    for (int i = 0; i < 4; i++) send(12'd1, 1'b0, 0, 24'($urandom), 24'($urandom));
    drain(2);
    check("t3_sops", 80'(n_sop - s0), 80'd4);
    check("t3_eops", 80'(n_eop - e0), 80'd4);

    // 3b: fftpts_in=0 means a 4096-point frame
    s0 = n_sop; e0 = n_eop;
    for (int i = 0; i < 4096; i++) send(12'd0, 1'b0, 0, 24'(i), 24'(~i));
    drain(2);
    check("t3b_sops", 80'(n_sop - s0), 80'd1);
    check("t3b_eops", 80'(n_eop - e0), 80'd1);

    // 4: random backpressure over three 64-point frames
    s0 = n_sop; e0 = n_eop;
    for (int i = 0; i < 192; i++) send(12'd64, 1'b0, 1, 24'($urandom), 24'($urandom));
    drain(6);
    check("t4_sops", 80'(n_sop - s0), 80'd3);
    check("t4_eops", 80'(n_eop - e0), 80'd3);

    // 5: resync on sample 5 of a 16-point frame
    s0 = n_sop; e0 = n_eop; r0 = n_err;
    for (int i = 0; i < 21; i++) send(12'd16, (i == 5), 0, 24'($urandom), 24'($urandom));
    drain(2);
    check("t5_sops", 80'(n_sop - s0), 80'd2);
    check("t5_eops", 80'(n_eop - e0), 80'd1);
    check("t5_errs", 80'(n_err - r0), 80'd1);

    // 6: reset with data held in the skid mid-frame
    source_ready = 1'b0;
    sink_valid   = 1'b1;
    fftpts_in    = 12'd16;
    for (int i = 0; i < 3; i++) begin
      sink_real = 24'(100 + i);
      sink_imag = 24'(200 + i);
      step();
    end
    check("t6_skid_full", 80'(sink_ready), 80'd0);
    sink_valid = 1'b0;
    rst_sync   = 1'b1;
    step();
    rst_sync   = 1'b0;
    check("t6_rst_valid", 80'(source_valid), 80'd0);
    check("t6_rst_ready", 80'(sink_ready), 80'd1);
    send(12'd16, 1'b0, 0, 24'h000123, 24'hFFF000);
    check("t6_valid", 80'(source_valid), 80'd1);
    check("t6_sop", 80'(source_sop), 80'd1);
    check("t6_real", 80'(source_real), 80'h00001230);
    drain(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
